// File: rtl/queue_pkg.sv
// Shared types for the queue front-end.
//   qsa_state_t : adapter FSM states (IDLE, PEEK, POP)
//   q_cmd_t     : the single queue command issued in a cycle
//   q_strobes_t : one-hot enqueue/dequeue/top strobes decoded from q_cmd_t
package queue_pkg;

  typedef enum logic [1:0] {ST_IDLE, ST_PEEK, ST_POP} qsa_state_t;

  typedef enum logic [1:0] {CMD_NONE, CMD_ENQ, CMD_DEQ, CMD_TOP} q_cmd_t;

  typedef struct packed {
    logic enq;
    logic deq;
    logic top;
  } q_strobes_t;

  // Request/grant bit positions shared by the top level and the arbiter.
  localparam int unsigned REQ_WR = 0;
  localparam int unsigned REQ_RD = 1;

  // One encoded command in, at most one strobe out.
  function automatic q_strobes_t cmd_decode(input q_cmd_t cmd);
    q_strobes_t s;
    s = '0;
    unique case (cmd)
      CMD_ENQ: s.enq = 1'b1;
      CMD_DEQ: s.deq = 1'b1;
      CMD_TOP: s.top = 1'b1;
      default: s = '0;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/queue_stream_adapter_rr_arbiter2.sv
// Two-way round-robin arbiter.
//   clk, rst : clock, asynchronous active-low reset
//   req[1:0] : requests (bit REQ_WR = write, bit REQ_RD = read)
//   gnt[1:0] : one-hot grant, combinational from req and the last-grant bit
// A lone request is granted directly; on contention the side not granted last
// wins. The last-grant bit only moves on a grant and resets so that the write
// side wins the first contention.
module rr_arbiter2
  import queue_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  // last_q = 1 means the read side was granted most recently.
  logic last_q;
  logic last_d;

  always_comb begin
    gnt    = '0;
    last_d = last_q;
    if (req == 2'b11) begin
      gnt[REQ_WR] = last_q;
      gnt[REQ_RD] = ~last_q;
    end else begin
      gnt = req;
    end
    if (gnt[REQ_WR]) begin
      last_d = 1'b0;
    end else if (gnt[REQ_RD]) begin
      last_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_q <= 1'b1;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/queue_stream_adapter.sv
// Front-end for the NxM queue: turns a producer valid/ready stream and a
// consumer valid/ready stream into one-hot queue commands.
//   clk, rst              : clock, asynchronous active-low reset
//   in_valid/in_ready     : producer handshake, in_data is the word
//   out_valid/out_ready   : consumer handshake, out_data is registered
//   q_enable              : high when any queue command is issued
//   q_enqueue/q_dequeue/q_top : one-hot queue commands
//   q_data_in             : word to enqueue (passes in_data through)
//   q_data_out            : queue's registered top data
//   q_full/q_empty        : queue status
//   wr_beats/rd_beats     : wrapping counts of enqueues / delivered words
// Writes enqueue in the grant cycle. Reads run IDLE(grant) -> PEEK(top) ->
// POP(dequeue + capture), so out_valid rises three cycles after the grant.
module queue_stream_adapter
  import queue_pkg::*;
#(
  parameter int unsigned BITWIDTH = 8,
  parameter int unsigned STATW    = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [BITWIDTH-1:0] in_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [BITWIDTH-1:0] out_data,
  output logic                q_enable,
  output logic                q_enqueue,
  output logic                q_dequeue,
  output logic                q_top,
  output logic [BITWIDTH-1:0] q_data_in,
  input  logic [BITWIDTH-1:0] q_data_out,
  input  logic                q_full,
  input  logic                q_empty,
  output logic [STATW-1:0]    wr_beats,
  output logic [STATW-1:0]    rd_beats
);

  qsa_state_t          state_q, state_d;
  logic                out_valid_q, out_valid_d;
  logic [BITWIDTH-1:0] out_data_q, out_data_d;
  logic [STATW-1:0]    wr_beats_q, wr_beats_d;
  logic [STATW-1:0]    rd_beats_q, rd_beats_d;

  logic [1:0] req;
  logic [1:0] gnt;
  q_cmd_t     cmd;
  q_strobes_t strb;

  // Requests only exist in IDLE; gating with rst keeps every command low
  // while reset is held, even though the state register already reads IDLE.
  always_comb begin
    req = '0;
    if (rst && (state_q == ST_IDLE)) begin
      req[REQ_WR] = in_valid & ~q_full;
      req[REQ_RD] = ~out_valid_q & ~q_empty;
    end
  end

  rr_arbiter2 u_arb (
    .clk (clk),
    .rst (rst),
    .req (req),
    .gnt (gnt)
  );

  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    wr_beats_d  = wr_beats_q;
    rd_beats_d  = rd_beats_q;
    cmd         = CMD_NONE;

    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
      rd_beats_d  = rd_beats_q + STATW'(1);
    end

    unique case (state_q)
      ST_IDLE: begin
        if (gnt[REQ_WR]) begin
          cmd        = CMD_ENQ;
          wr_beats_d = wr_beats_q + STATW'(1);
        end else if (gnt[REQ_RD]) begin
          state_d = ST_PEEK;
        end
      end
      ST_PEEK: begin
        cmd     = CMD_TOP;
        state_d = ST_POP;
      end
      ST_POP: begin
        // q_data_out became valid this cycle from the preceding top command.
        cmd         = CMD_DEQ;
        out_data_d  = q_data_out;
        out_valid_d = 1'b1;
        state_d     = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      wr_beats_q  <= '0;
      rd_beats_q  <= '0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      wr_beats_q  <= wr_beats_d;
      rd_beats_q  <= rd_beats_d;
    end
  end

  assign strb      = cmd_decode(cmd);
  assign q_enqueue = strb.enq;
  assign q_dequeue = strb.deq;
  assign q_top     = strb.top;
  assign q_enable  = strb.enq | strb.deq | strb.top;
  assign in_ready  = strb.enq;
  assign q_data_in = in_data;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign wr_beats  = wr_beats_q;
  assign rd_beats  = rd_beats_q;

  a_full_empty_exclusive : assert property (
    @(posedge clk) disable iff (!rst) !(q_full && q_empty)
  );

endmodule
